// File: rtl/dds_sweep_ctrl.sv
// Frequency sweep sequencer for one dds_slave channel: ramps the frequency
// word from start to stop with a per-step dwell, then optionally launches a
// phase adjustment and waits for its completion edge.
module dds_sweep_ctrl #(
  parameter logic [31:0] ADJ_TIMEOUT = 32'd2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] f_start,
  input  logic [31:0] f_stop,
  input  logic [31:0] f_step,
  input  logic [31:0] dwell,
  input  logic        ph_adj_en,
  input  logic [31:0] desired_phase,
  input  logic [31:0] delay_time,
  input  logic [31:0] work_time,
  input  logic        dds_ph_adj_ready,
  output logic [31:0] dds_freq,
  output logic        dds_synch,
  output logic        dds_ph_adj_start,
  output logic [31:0] dds_desired_phase,
  output logic [31:0] dds_delay_time,
  output logic [31:0] dds_work_time,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  state
);

  localparam int unsigned W = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DWELL    = 2'd1,
    S_ADJ_WAIT = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t         cur, nxt;
  logic [W-1:0]   stop_q, step_q, dwell_q;
  logic           adj_en_q, up_q, ready_q;
  logic [W-1:0]   cnt_q, cnt_nxt, tcnt_q, tcnt_nxt, tcnt_inc;
  logic [W-1:0]   freq_nxt, step_val;
  logic           synch_nxt, adj_start_nxt, err_nxt, load;
  logic [W:0]     sum_w, diff_w;

  assign state = cur;

  // Next ramp value: 33-bit add/subtract, clamped to the stop word
  always_comb begin
    sum_w  = {1'b0, dds_freq} + {1'b0, step_q};
    diff_w = {1'b0, dds_freq} - {1'b0, step_q};
    if (step_q == '0) begin
      step_val = stop_q;
    end else if (up_q) begin
      step_val = (sum_w > {1'b0, stop_q}) ? stop_q : sum_w[W-1:0];
    end else begin
      step_val = (diff_w[W] || (diff_w[W-1:0] < stop_q)) ? stop_q : diff_w[W-1:0];
    end
  end

  // Next-state and next-output decode
  always_comb begin
    nxt           = cur;
    freq_nxt      = dds_freq;
    synch_nxt     = 1'b0;
    adj_start_nxt = 1'b0;
    err_nxt       = err;
    cnt_nxt       = cnt_q;
    tcnt_nxt      = tcnt_q;
    tcnt_inc      = tcnt_q + W'(1);
    load          = 1'b0;
    unique case (cur)
      S_IDLE: begin
        if (start && !abort) begin
          load      = 1'b1;
          freq_nxt  = f_start;
          synch_nxt = 1'b1;
          cnt_nxt   = W'(1);
          err_nxt   = 1'b0;
          nxt       = S_DWELL;
        end
      end
      S_DWELL: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (cnt_q == dwell_q) begin
          if (dds_freq != stop_q) begin
            freq_nxt  = step_val;
            synch_nxt = 1'b1;
            cnt_nxt   = W'(1);
          end else if (adj_en_q) begin
            adj_start_nxt = 1'b1;
            tcnt_nxt      = '0;
            nxt           = S_ADJ_WAIT;
          end else begin
            nxt = S_DONE;
          end
        end else begin
          cnt_nxt = cnt_q + W'(1);
        end
      end
      S_ADJ_WAIT: begin
        if (abort) begin
          nxt = S_IDLE;
        end else if (dds_ph_adj_ready && !ready_q) begin
          nxt = S_DONE;
        end else begin
          tcnt_nxt = tcnt_inc;
          if (tcnt_inc >= ADJ_TIMEOUT) begin
            err_nxt = 1'b1;
            nxt     = S_IDLE;
          end
        end
      end
      S_DONE: begin
        nxt = S_IDLE;
      end
    endcase
  end

  // State, output and command-latch registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cur               <= S_IDLE;
      dds_freq          <= '0;
      dds_synch         <= 1'b0;
      dds_ph_adj_start  <= 1'b0;
      dds_desired_phase <= '0;
      dds_delay_time    <= '0;
      dds_work_time     <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      cnt_q             <= '0;
      tcnt_q            <= '0;
      ready_q           <= 1'b0;
      stop_q            <= '0;
      step_q            <= '0;
      dwell_q           <= '0;
      adj_en_q          <= 1'b0;
      up_q              <= 1'b0;
    end else begin
      cur              <= nxt;
      dds_freq         <= freq_nxt;
      dds_synch        <= synch_nxt;
      dds_ph_adj_start <= adj_start_nxt;
      busy             <= (nxt != S_IDLE);
      done             <= (nxt == S_DONE);
      err              <= err_nxt;
      cnt_q            <= cnt_nxt;
      tcnt_q           <= tcnt_nxt;
      ready_q          <= dds_ph_adj_ready;
      if (load) begin
        stop_q            <= f_stop;
        step_q            <= f_step;
        dwell_q           <= (dwell == '0) ? W'(1) : dwell;
        adj_en_q          <= ph_adj_en;
        up_q              <= (f_stop >= f_start);
        dds_desired_phase <= desired_phase;
        dds_delay_time    <= delay_time;
        dds_work_time     <= work_time;
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed scenarios plus randomized
// ramps compared against an arithmetic model of the ramp value sequence.
module tb_dds_sweep_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, abort, ph_adj_en, dds_ph_adj_ready;
  logic [31:0] f_start, f_stop, f_step, dwell;
  logic [31:0] desired_phase, delay_time, work_time;
  logic [31:0] dds_freq, dds_desired_phase, dds_delay_time, dds_work_time;
  logic        dds_synch, dds_ph_adj_start, busy, done, err;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] vals[$];

  dds_sweep_ctrl #(.ADJ_TIMEOUT(32'd100)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell),
    .ph_adj_en(ph_adj_en), .desired_phase(desired_phase),
    .delay_time(delay_time), .work_time(work_time),
    .dds_ph_adj_ready(dds_ph_adj_ready), .dds_freq(dds_freq),
    .dds_synch(dds_synch), .dds_ph_adj_start(dds_ph_adj_start),
    .dds_desired_phase(dds_desired_phase), .dds_delay_time(dds_delay_time),
    .dds_work_time(dds_work_time), .busy(busy), .done(done), .err(err),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Model: list of distinct frequency words visited by a ramp
  task automatic build_vals(input logic [31:0] fs, input logic [31:0] fp, input logic [31:0] st);
    longint v, nv, stop_v, step_v;
    v = longint'(fs);
    stop_v = longint'(fp);
    step_v = longint'(st);
    vals.delete();
    vals.push_back(fs);
    for (int i = 0; i < 1000 && v != stop_v; i++) begin
      if (step_v == 0) nv = stop_v;
      else if (fp >= fs) begin
        nv = v + step_v;
        if (nv > stop_v) nv = stop_v;
      end else begin
        nv = v - step_v;
        if (nv < stop_v) nv = stop_v;
      end
      v = nv;
      vals.push_back(32'(v));
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_synch"}, 32'(dds_synch), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_adjst"}, 32'(dds_ph_adj_start), 32'd0);
  endtask

  // Runs one ramp cycle-by-cycle; optional abort/reset at kill_k and a
  // spurious start at bstart_k. With adj=1 it returns in the first ADJ_WAIT cycle.
  task automatic run_ramp(input logic [31:0] fs, input logic [31:0] fp, input logic [31:0] st,
                          input logic [31:0] dw, input bit adj, input logic [31:0] ph,
                          input int kill_k, input bit kill_rst, input int bstart_k);
    int d, last;
    build_vals(fs, fp, st);
    d = (dw == 0) ? 1 : int'(dw);
    last = vals.size() * d;
    @(negedge clk);
    f_start = fs; f_stop = fp; f_step = st; dwell = dw; ph_adj_en = adj;
    desired_phase = ph; delay_time = ph ^ 32'h5555_5555; work_time = ~ph;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k < last) begin
        chk("synch", 32'(dds_synch), (k % d == 0) ? 32'd1 : 32'd0);
        chk("freq", dds_freq, vals[k / d]);
        chk("state_dwell", 32'(state), 32'd1);
        chk("busy", 32'(busy), 32'd1);
        chk("err_ramp", 32'(err), 32'd0);
        chk("done_ramp", 32'(done), 32'd0);
      end else begin
        chk("freq_end", dds_freq, fp);
        chk("synch_end", 32'(dds_synch), 32'd0);
        if (adj) begin
          chk("adj_start", 32'(dds_ph_adj_start), 32'd1);
          chk("state_adj", 32'(state), 32'd2);
          chk("des_phase", dds_desired_phase, ph);
          chk("delay_time", dds_delay_time, ph ^ 32'h5555_5555);
          chk("work_time", dds_work_time, ~ph);
        end else begin
          chk("done_end", 32'(done), 32'd1);
          chk("state_done", 32'(state), 32'd3);
          chk("adj_none", 32'(dds_ph_adj_start), 32'd0);
        end
      end
      if (k == last) break;
      start = (k == bstart_k);
      abort = (k == kill_k) && !kill_rst;
      reset = (k == kill_k) && kill_rst;
      if (k == bstart_k) begin
        f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 32'd1;
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; reset = 1'b0;
      if (k == kill_k) begin
        for (int j = 0; j < 4; j++) begin
          chk_idle("kill");
          chk("kill_freq", dds_freq, kill_rst ? 32'd0 : vals[k / d]);
          if (kill_rst) chk("kill_phase", dds_desired_phase, 32'd0);
          @(negedge clk);
        end
        return;
      end
    end
    if (!adj) begin
      @(negedge clk);
      chk_idle("post_done");
      chk("hold_freq", dds_freq, fp);
    end
  endtask

  initial begin
    logic [31:0] fs, fp, st, diff;
    reset = 1'b1; start = 1'b0; abort = 1'b0; ph_adj_en = 1'b0; dds_ph_adj_ready = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    desired_phase = '0; delay_time = '0; work_time = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    chk("reset_freq", dds_freq, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    chk("reset_phase", dds_desired_phase, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("after_reset");

    // Up ramp and clamped down ramp with dwell 0
    run_ramp(32'h0147AE14, 32'h06666664, 32'h0147AE14, 32'd3, 1'b0, 32'd0, -1, 1'b0, -1);
    run_ramp(32'h05000000, 32'h00800000, 32'h02000000, 32'd0, 1'b0, 32'd0, -1, 1'b0, -1);

    // Phase adjust completed by a ready edge 50 cycles later
    run_ramp(32'h0147AE14, 32'h06666664, 32'h0147AE14, 32'd3, 1'b1, 32'h80000000, -1, 1'b0, -1);
    for (int c = 1; c < 50; c++) begin
      @(negedge clk);
      chk("adj_wait", 32'(state), 32'd2);
      chk("adj_pulse_once", 32'(dds_ph_adj_start), 32'd0);
    end
    dds_ph_adj_ready = 1'b1;
    @(negedge clk);
    chk("adj_done", 32'(done), 32'd1);
    chk("adj_done_state", 32'(state), 32'd3);
    chk("adj_err", 32'(err), 32'd0);
    chk("adj_phase", dds_desired_phase, 32'h80000000);
    @(negedge clk);
    chk_idle("adj_idle");
    dds_ph_adj_ready = 1'b0;

    // Ready already high on entry is not a completion edge
    dds_ph_adj_ready = 1'b1;
    run_ramp(32'h10, 32'h30, 32'h10, 32'd1, 1'b1, $urandom, -1, 1'b0, -1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("level_ignored", 32'(state), 32'd2);
    end
    dds_ph_adj_ready = 1'b0;
    @(negedge clk);
    chk("level_low", 32'(state), 32'd2);
    dds_ph_adj_ready = 1'b1;
    @(negedge clk);
    chk("level_edge_done", 32'(done), 32'd1);
    @(negedge clk);
    chk_idle("level_idle");
    dds_ph_adj_ready = 1'b0;

    // Timeout after 100 ADJ_WAIT cycles
    run_ramp(32'h100, 32'h300, 32'h100, 32'd2, 1'b1, 32'h1234, -1, 1'b0, -1);
    for (int c = 1; c < 100; c++) begin
      @(negedge clk);
      chk("to_wait", 32'(state), 32'd2);
      chk("to_nodone", 32'(done), 32'd0);
      chk("to_noerr", 32'(err), 32'd0);
    end
    @(negedge clk);
    chk_idle("timeout");
    chk("to_err", 32'(err), 32'd1);

    // abort+start together in IDLE: start dropped, err stays set
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk_idle("abort_start");
    chk("abort_start_err", 32'(err), 32'd1);

    // Next accepted start clears err (checked during ramp)
    run_ramp(32'h20, 32'h10, 32'h8, 32'd1, 1'b0, 32'd0, -1, 1'b0, -1);

    // Busy start ignored, abort on 2nd dwell cycle of step 3
    run_ramp(32'h0147AE14, 32'h06666664, 32'h0147AE14, 32'd3, 1'b0, 32'd0, 7, 1'b0, 3);

    // Reset mid-ramp, then a clean ramp
    run_ramp(32'h05000000, 32'h00800000, 32'h02000000, 32'd2, 1'b1, 32'hCAFE0000, 3, 1'b1, -1);
    run_ramp(32'h0147AE14, 32'h06666664, 32'h0147AE14, 32'd3, 1'b0, 32'd0, -1, 1'b0, -1);

    // Boundaries: carry, borrow, zero step, equal start/stop
    run_ramp(32'hFFFFFF00, 32'hFFFFFFF0, 32'h80000000, 32'd1, 1'b0, 32'd0, -1, 1'b0, -1);
    run_ramp(32'h00000100, 32'h00000010, 32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, -1, 1'b0, -1);
    run_ramp(32'h00000005, 32'h12345678, 32'h00000000, 32'd2, 1'b0, 32'd0, -1, 1'b0, -1);
    run_ramp(32'h00000ABC, 32'h00000ABC, 32'h00000010, 32'd4, 1'b0, 32'd0, -1, 1'b0, -1);

    // Randomized ramps
    for (int r = 0; r < 10; r++) begin
      fs = $urandom; fp = $urandom;
      diff = (fp >= fs) ? fp - fs : fs - fp;
      st = diff / 32'($urandom_range(1, 6)) + 32'($urandom_range(0, 3));
      run_ramp(fs, fp, st, 32'($urandom_range(0, 4)), 1'b0, 32'd0, -1, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Sequencer for one `dds_slave` channel. It steps the channel's frequency word from a start value to a stop value with a programmable dwell per step, and pulses `synch` on every update. At the end of the ramp it can optionally launch a phase adjustment and wait for completion. It sits between the register/command layer and `dds_slave`, and drives that block's `freq`, `synch`, `ph_adj_start`, `desired_phase`, `delay_time` and `work_time` inputs.

## Interface
- `ADJ_TIMEOUT`, default 32'd2_000_000: maximum ADJ_WAIT cycles before `err` (≈10.5 ms at 190 MHz).
- `clk` in 1: system clock (190 MHz).
- `reset` in 1: **one clock; reset is synchronous and active-high.**
- `start` in 1: command strobe; sampled only in IDLE.
- `abort` in 1: terminates any operation.
- `f_start`, `f_stop`, `f_step` in 32 each: frequency words, Freq·2^32/F_clk. `f_step` is an unsigned magnitude.
- `dwell` in 32: cycles per frequency value; 0 is treated as 1.
- `ph_adj_en` in 1: 1 = run a phase adjustment after the ramp.
- `desired_phase`, `delay_time`, `work_time` in 32 each: phase-adjust arguments.
- `dds_ph_adj_ready` in 1: from `dds_slave.ph_adj_ready`.
- `dds_freq` out 32: to `dds_slave.freq`.
- `dds_synch` out 1: to `dds_slave.synch`; 1-cycle pulses.
- `dds_ph_adj_start` out 1: 1-cycle pulse.
- `dds_desired_phase`, `dds_delay_time`, `dds_work_time` out 32 each: latched copies of the phase-adjust arguments.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: 1-cycle pulse on normal completion.
- `err` out 1: sticky timeout flag; cleared by the next accepted `start` or by `reset`.
- `state` out 2: IDLE=0, DWELL=1, ADJ_WAIT=2, DONE=3.

## Operation
- **Reset.** All outputs are 0, state is IDLE and all counters are 0.
- **IDLE + start=1.** Latch all command inputs. In the same edge:
  - `dds_freq` ← `f_start`, `dds_synch` ← 1;
  - dwell counter ← 1, `err` ← 0, state ← DWELL.
- **Start while busy.** Ignored.
- **Direction.** Up if `f_stop` ≥ `f_start`, else down. Direction is fixed at latch time.
- **DWELL.** The counter increments each cycle. When counter == max(`dwell`,1):
  - if `dds_freq` != `f_stop`, step the frequency: `dds_freq` ← next, `dds_synch` ← 1, counter ← 1;
  - else if `ph_adj_en`: `dds_ph_adj_start` ← 1, timeout counter ← 0, state ← ADJ_WAIT;
  - else state ← DONE.
- **Next-value arithmetic.** Computed in 33 bits, with no modular wrap.
  - Up: `dds_freq` + `f_step`; if the sum exceeds `f_stop` (including carry out of bit 31), use `f_stop`.
  - Down: `dds_freq` − `f_step`; if the result is below `f_stop` (including borrow), use `f_stop`.
  - `f_step` = 0: next = `f_stop`, i.e. a single jump.
  - `f_start` == `f_stop`: one synch only, then the end-of-ramp action.
- **ADJ_WAIT.**
  - A rising edge of `dds_ph_adj_ready` (registered previous value 0, current 1) → DONE. A level already high on entry is not accepted.
  - The timeout counter increments each cycle. When it reaches `ADJ_TIMEOUT`: `err` ← 1, state ← IDLE, no `done`.
- **DONE.** `done`=1 for one cycle, then IDLE.
- **abort=1 in any non-IDLE state.** State ← IDLE on that edge; no `done`, no `synch`, no `ph_adj_start`. `dds_freq` holds its last value.
- **abort and start together in IDLE.** `abort` has priority and `start` is dropped.
- **Output holding.** `dds_freq` and the `dds_*` argument outputs hold their values in IDLE.

## Timing
- `start` high at edge N → `dds_freq`=`f_start` and `dds_synch`=1 during cycle N+1.
- `dds_synch` is registered and rises on the same edge as the `dds_freq` update. `dds_slave` therefore captures the new word on the following edge.
- Consecutive `dds_synch` pulses are exactly max(`dwell`,1) cycles apart. `dwell`=1 gives back-to-back pulses.
- Final value: after the last `synch`, `dds_freq` holds for max(`dwell`,1) cycles, then one of:
  - `dds_ph_adj_start` rises;
  - `done` rises the following cycle (no adjustment).
- Ready edge: a `dds_ph_adj_ready` rising edge at edge M → state DONE at M+1, `done`=1 during cycle M+1.
- Ramp length: total synch pulses K = number of distinct values from `f_start` to `f_stop` inclusive under the clamp rule. Ramp duration = K·max(`dwell`,1) cycles.
- `abort` or `reset` at edge N → IDLE visible in cycle N+1. Mid-ramp `reset` additionally zeroes `dds_freq`.

## Test plan
- **Up ramp.** `f_start`=0x0147AE14, `f_step`=0x0147AE14, `f_stop`=0x06666664, `dwell`=3, `ph_adj_en`=0.
  - 5 synch pulses, 3 cycles apart, with `dds_freq` = 0x0147AE14, 0x028F5C28, 0x03D70A3C, 0x051EB850, 0x06666664.
  - `done` 3 cycles after the last synch.
- **Clamp down ramp.** `f_start`=0x05000000, `f_stop`=0x00800000, `f_step`=0x02000000, `dwell`=0.
  - Values 0x05000000, 0x03000000, 0x01000000, 0x00800000 on back-to-back pulses.
- **Phase adjust.** Up-ramp settings with `ph_adj_en`=1 and `desired_phase`=0x80000000.
  - `dds_ph_adj_start` pulses once and `dds_desired_phase`=0x80000000.
  - Raise ready 50 cycles later → `done` on the next cycle, `err`=0.
- **Timeout.** `ADJ_TIMEOUT`=100, ready held low.
  - `err`=1 and IDLE after 100 ADJ_WAIT cycles, no `done`.
  - `err` clears on the next `start`.
- **Abort and busy start.** `abort` on the 2nd dwell cycle of step 3 → IDLE next cycle, `dds_freq` holds step-3 value, no further pulses. A `start` pulsed while busy changes nothing.
- **Reset mid-ramp.** Synchronous `reset` during DWELL → all outputs 0 next cycle. A subsequent `start` begins a clean ramp.
